sisc_exec_ctrl: RTL and testbench

//  SISC multi-cycle control FSM, 32-bit ALU and branch-target unit in one block.

---
 rtl/sisc_exec_ctrl_if.sv | 50 +++++
 rtl/sisc_exec_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sisc_exec_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sisc_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// sisc_exec_ctrl_if
// Bundle between the SISC execution controller and its surrounding datapath
// (instruction register, register file, status register, program counter).
//
// Datapath -> controller:
//   ir       [31:0]  instruction word {opcode, mm, rd, rs, imm}
//   stat     [3:0]   registered flags {C,V,N,Z}
//   rega     [31:0]  register-file port A
//   regb     [31:0]  register-file port B
//   pc_out   [15:0]  current program counter
// Controller -> datapath:
//   rf_we, wb_sel, rb_sel, ir_load, pc_rst, pc_write, pc_sel, stat_en,
//   br_sel   (branch-address mode, 1 = pc-relative)
//   alu_out  [31:0], alu_sts [3:0], br_addr [15:0]
//
// master: the datapath side; slave: the controller.
// ---------------------------------------------------------------------------
interface sisc_exec_ctrl_if;
    logic [31:0] ir;
    logic [3:0]  stat;
    logic [31:0] rega;
    logic [31:0] regb;
    logic [15:0] pc_out;

    logic        rf_we;
    logic        wb_sel;
    logic        rb_sel;
    logic        ir_load;
    logic        pc_rst;
    logic        pc_write;
    logic        pc_sel;
    logic        stat_en;
    logic        br_sel;
    logic [31:0] alu_out;
    logic [3:0]  alu_sts;
    logic [15:0] br_addr;

    modport master (
        output ir, stat, rega, regb, pc_out,
        input  rf_we, wb_sel, rb_sel, ir_load, pc_rst, pc_write, pc_sel,
               stat_en, br_sel, alu_out, alu_sts, br_addr
    );

    modport slave (
        input  ir, stat, rega, regb, pc_out,
        output rf_we, wb_sel, rb_sel, ir_load, pc_rst, pc_write, pc_sel,
               stat_en, br_sel, alu_out, alu_sts, br_addr
    );
endinterface

// File: rtl/sisc_exec_ctrl.sv
// ---------------------------------------------------------------------------
// sisc_exec_ctrl
// Multi-cycle SISC controller: sequences fetch/decode/execute/mem/writeback,
// drives PC/IR/register-file/status strobes, and contains the 32-bit ALU and
// the 16-bit branch-target adder. ALU, flags and branch address are purely
// combinational; only the sequencer state is registered.
//
// Ports:
//   clk    rising-edge clock
//   rst_f  asynchronous, active-low reset (returns to START0 at once)
//   bus    sisc_exec_ctrl_if.slave, see the interface for signal list
// ---------------------------------------------------------------------------
module sisc_exec_ctrl (
    input  logic            clk,
    input  logic            rst_f,
    sisc_exec_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_ALU_REG = 4'b0001;
    localparam logic [3:0] OP_ALU_IMM = 4'b0010;
    localparam logic [3:0] OP_BRA     = 4'b0100;
    localparam logic [3:0] OP_BRR     = 4'b0101;
    localparam logic [3:0] OP_BNE     = 4'b0110;
    localparam logic [3:0] OP_BNR     = 4'b0111;
    localparam logic [3:0] OP_HLT     = 4'b1111;

    state_t state;
    state_t state_nxt;

    logic [3:0]         opcode;
    logic [3:0]         mm;
    logic [15:0]        imm;
    logic               alu_wr;
    logic               br_taken;
    logic signed [31:0] opa;
    logic signed [31:0] opb;
    logic [35:0]        alu_res;
    logic               unused_fields;

    assign opcode = bus.ir[31:28];
    assign mm     = bus.ir[27:24];
    assign imm    = bus.ir[15:0];

    // rd/rs select the register file outside this block.
    assign unused_fields = ^bus.ir[23:16];

    // mm==0000 makes an ALU opcode behave as a no-op for state updates.
    assign alu_wr = ((opcode == OP_ALU_REG) || (opcode == OP_ALU_IMM)) && (mm != 4'b0000);

    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            OP_BRA, OP_BRR: br_taken = (mm == 4'b0000) || ((mm & bus.stat) != 4'b0000);
            OP_BNE, OP_BNR: br_taken = ((mm & bus.stat) == 4'b0000);
            default:        br_taken = 1'b0;
        endcase
    end

    // ALU returns {C, V, N, Z, result}.
    function automatic logic [35:0] alu_eval(
        input logic [3:0]         fn,
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        logic [32:0] sum;
        logic [31:0] res;
        logic [63:0] rot;
        logic [4:0]  sh;
        logic        c;
        logic        v;
        sum = '0;
        res = a;
        c   = 1'b0;
        v   = 1'b0;
        sh  = b[4:0];
        // Upper half of the doubled word shifted left is the left rotation.
        rot = {a, a} << sh;
        case (fn)
            4'h1: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[31:0];
                c   = sum[32];
                v   = (a[31] == b[31]) && (res[31] != a[31]);
            end
            4'h2: begin
                // Subtract as A + ~B + 1 so that C is the inverted borrow.
                sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
                res = sum[31:0];
                c   = sum[32];
                v   = (a[31] != b[31]) && (res[31] != a[31]);
            end
            4'h3:    res = ~a;
            4'h4:    res = a | b;
            4'h5:    res = a & b;
            4'h6:    res = a ^ b;
            4'h7:    res = rot[63:32];
            4'h8:    res = $unsigned(a) << sh;
            4'h9:    res = $unsigned(a) >> sh;
            default: res = a;
        endcase
        return {c, v, res[31], (res == 32'd0), res};
    endfunction

    assign opa     = bus.rega;
    assign opb     = (opcode == OP_ALU_IMM) ? {{16{imm[15]}}, imm} : bus.regb;
    assign alu_res = alu_eval(mm, opa, opb);

    assign bus.alu_out = alu_res[31:0];
    assign bus.alu_sts = alu_res[35:32];

    assign bus.br_sel  = (opcode == OP_BRR) || (opcode == OP_BNR);
    assign bus.br_addr = bus.br_sel ? (bus.pc_out + imm) : imm;

    // State register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= S_START0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_START0:    state_nxt = S_START1;
            S_START1:    state_nxt = S_FETCH;
            S_FETCH:     state_nxt = S_DECODE;
            S_DECODE:    state_nxt = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   state_nxt = S_MEM;
            S_MEM:       state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_FETCH;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_START0;
        endcase
    end

    // Output decode (Moore state plus current ir)
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.rb_sel   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.pc_rst   = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.stat_en  = 1'b0;
        case (state)
            S_START0, S_START1: bus.pc_rst = 1'b1;
            S_FETCH: begin
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
                bus.pc_sel   = 1'b0;
            end
            S_DECODE: begin
                if (br_taken) begin
                    bus.pc_write = 1'b1;
                    bus.pc_sel   = 1'b1;
                end
            end
            S_EXECUTE:   bus.stat_en = alu_wr;
            S_WRITEBACK: bus.rf_we   = alu_wr;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sisc_exec_ctrl
// Per-cycle scoreboard bench: the driver pushes the expected outputs for each
// cycle as it drives it; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_sisc_exec_ctrl;

    logic clk;
    logic rst_f;

    sisc_exec_ctrl_if bus ();

    sisc_exec_ctrl dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bit packing: {rf_we, wb_sel, rb_sel, ir_load, pc_rst, pc_write, pc_sel, stat_en, br_sel}
    localparam logic [8:0] C_NONE  = 9'h000;
    localparam logic [8:0] C_RF_WE = 9'h100;
    localparam logic [8:0] C_IRL   = 9'h020;
    localparam logic [8:0] C_PCRST = 9'h010;
    localparam logic [8:0] C_PCW   = 9'h008;
    localparam logic [8:0] C_PCSEL = 9'h004;
    localparam logic [8:0] C_STEN  = 9'h002;
    localparam logic [8:0] C_BRSEL = 9'h001;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] alu;
        logic [3:0]  sts;
        logic [15:0] br;
    } exp_t;

    exp_t  q_exp[$];
    string q_nm[$];
    int    tests;
    int    fails;

    // Reference ALU: wide integer arithmetic, range checks for overflow.
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [3:0] fn,
                                            input logic [31:0] a, input logic [31:0] rb,
                                            input logic [15:0] imm);
        logic [31:0]     b;
        logic [31:0]     res;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ur;
        longint          sa;
        longint          sb;
        longint          sr;
        logic            c;
        logic            v;
        b  = (op == 4'h2) ? {{16{imm[15]}}, imm} : rb;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        c  = 1'b0;
        v  = 1'b0;
        res = a;
        case (fn)
            4'h1: begin
                ur  = ua + ub;
                res = ur[31:0];
                c   = (ur >= 64'h1_0000_0000);
                sr  = sa + sb;
                v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h2: begin
                res = a - b;
                c   = (ua >= ub);
                sr  = sa - sb;
                v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h3: res = ~a;
            4'h4: res = a | b;
            4'h5: res = a & b;
            4'h6: res = a ^ b;
            4'h7: for (int i = 0; i < int'(b[4:0]); i++) res = {res[30:0], res[31]};
            4'h8: for (int i = 0; i < int'(b[4:0]); i++) res = {res[30:0], 1'b0};
            4'h9: for (int i = 0; i < int'(b[4:0]); i++) res = {1'b0, res[31:1]};
            default: res = a;
        endcase
        return {c, v, res[31], (res == 32'd0), res};
    endfunction

    function automatic logic ref_taken(input logic [3:0] op, input logic [3:0] fn, input logic [3:0] st);
        if (op == 4'h4 || op == 4'h5) return (fn == 4'h0) || ((fn & st) != 4'h0);
        if (op == 4'h6 || op == 4'h7) return ((fn & st) == 4'h0);
        return 1'b0;
    endfunction

    // Expected outputs for the cycle now being driven, then advance one cycle.
    task automatic issue(input string nm, input logic [8:0] ctrl);
        exp_t        e;
        logic [35:0] r;
        logic        rel;
        r   = ref_alu(bus.ir[31:28], bus.ir[27:24], bus.rega, bus.regb, bus.ir[15:0]);
        rel = (bus.ir[31:28] == 4'h5) || (bus.ir[31:28] == 4'h7);
        e.ctrl = ctrl | (rel ? C_BRSEL : C_NONE);
        e.alu  = r[31:0];
        e.sts  = r[35:32];
        e.br   = rel ? 16'(bus.pc_out + bus.ir[15:0]) : bus.ir[15:0];
        q_exp.push_back(e);
        q_nm.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        issue("reset_hold", C_PCRST);
        issue("reset_hold", C_PCRST);
        rst_f = 1'b1;
        issue("start0", C_PCRST);
        issue("start1", C_PCRST);
    endtask

    task automatic run_instr(input logic [31:0] instr, input logic [3:0] st,
                             input logic [31:0] a, input logic [31:0] b, input logic [15:0] pc);
        logic [3:0] op;
        logic [3:0] fn;
        logic       wr;
        bus.ir     = instr;
        bus.stat   = st;
        bus.rega   = a;
        bus.regb   = b;
        bus.pc_out = pc;
        op = instr[31:28];
        fn = instr[27:24];
        wr = ((op == 4'h1) || (op == 4'h2)) && (fn != 4'h0);
        issue("fetch", C_IRL | C_PCW);
        if (op == 4'hF) begin
            issue("decode_hlt", C_NONE);
            repeat (20) issue("halt", C_NONE);
            do_reset();
        end else begin
            issue("decode", ref_taken(op, fn, st) ? (C_PCW | C_PCSEL) : C_NONE);
            issue("execute", wr ? C_STEN : C_NONE);
            issue("mem", C_NONE);
            issue("writeback", wr ? C_RF_WE : C_NONE);
        end
    endtask

    exp_t        mon_e;
    exp_t        mon_a;
    string       mon_nm;

    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            mon_e  = q_exp.pop_front();
            mon_nm = q_nm.pop_front();
            mon_a.ctrl = {bus.rf_we, bus.wb_sel, bus.rb_sel, bus.ir_load, bus.pc_rst,
                          bus.pc_write, bus.pc_sel, bus.stat_en, bus.br_sel};
            mon_a.alu  = bus.alu_out;
            mon_a.sts  = bus.alu_sts;
            mon_a.br   = bus.br_addr;
            tests++;
            if (mon_a !== mon_e) begin
                fails++;
                $display("FAIL %s ir=%h: got ctrl=%b alu=%h sts=%b br=%h, expected ctrl=%b alu=%h sts=%b br=%h",
                         mon_nm, bus.ir, mon_a.ctrl, mon_a.alu, mon_a.sts, mon_a.br,
                         mon_e.ctrl, mon_e.alu, mon_e.sts, mon_e.br);
            end
        end
    end

    logic [3:0] rop;

    initial begin
        tests      = 0;
        fails      = 0;
        rst_f      = 1'b1;
        bus.ir     = 32'h0000_0000;
        bus.stat   = 4'h0;
        bus.rega   = 32'h0;
        bus.regb   = 32'h0;
        bus.pc_out = 16'h0;
        #2;
        rst_f = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed cases
        run_instr({4'h1, 4'h1, 8'h00, 16'h0000}, 4'h0, 32'h7, 32'h5, 16'h0003);          // ADD
        run_instr({4'h1, 4'h2, 8'h00, 16'h0000}, 4'h0, 32'h5, 32'h5, 16'h0004);          // SUB -> Z,C
        run_instr({4'h2, 4'h1, 8'h00, 16'h0001}, 4'h0, 32'h7FFF_FFFF, 32'h0, 16'h0005);  // ADI overflow
        run_instr({4'h5, 4'h1, 8'h00, 16'hFFFE}, 4'h1, 32'h0, 32'h0, 16'h0010);          // BRR taken
        run_instr({4'h6, 4'h1, 8'h00, 16'h0040}, 4'h1, 32'h0, 32'h0, 16'h0011);          // BNE not taken
        run_instr({4'h4, 4'h0, 8'h00, 16'h1234}, 4'h0, 32'h0, 32'h0, 16'h0012);          // BRA unconditional
        run_instr({4'h7, 4'h2, 8'h00, 16'h0005}, 4'h1, 32'h0, 32'h0, 16'hFFFE);          // BNR wrap
        run_instr({4'h1, 4'h7, 8'h00, 16'h0000}, 4'h0, 32'h8000_0001, 32'h1, 16'h0);     // ROTL
        run_instr({4'h1, 4'h9, 8'h00, 16'h0000}, 4'h0, 32'h8000_0000, 32'h1F, 16'h0);    // SHR
        run_instr({4'h1, 4'h0, 8'h00, 16'h0000}, 4'h0, 32'h0, 32'h0, 16'h0);             // ALU mm=0
        run_instr({4'hF, 4'h0, 8'h00, 16'h0000}, 4'h0, 32'h1, 32'h2, 16'h0);             // HLT + reset

        // Reset in the middle of an instruction
        bus.ir = {4'h1, 4'h1, 8'h00, 16'h0000};
        issue("fetch", C_IRL | C_PCW);
        issue("decode", C_NONE);
        do_reset();

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            rop = 4'($urandom_range(0, 15));
            run_instr({rop, 4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom)},
                      4'($urandom), $urandom, $urandom, 16'($urandom));
        end

        for (int i = 0; i < 4 && q_exp.size() != 0; i++) @(negedge clk);
        if (q_exp.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending entries, expected 0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
